memory_writeback_unit: RTL and testbench
========================================

MEMORY_WRITEBACK_UNIT -- requirements
Module: memory_writeback_unit

Interface
REQ-001 Parameter: TIMEOUT, 8, maximum WAIT_MEM cycles before a load is abandoned (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: valid_in  input  1  upstream memory-wait stage presents an instruction.
REQ-005 Port: ready_out  output  1  this stage accepts an instruction this cycle.
REQ-006 Port: instr_in  input  32  ARM instruction word from the memory-wait stage.
REQ-007 Port: pc_in  input  7  instruction address from the memory-wait stage.
REQ-008 Port: alu_in  input  32  execute result for data-processing instructions.
REQ-009 Port: mem_rdata  input  32  data-memory read data.
REQ-010 Port: mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-011 Port: w_en  output  1  register-file write strobe.
REQ-012 Port: w_addr  output  4  register-file write index.
REQ-013 Port: w_data  output  32  register-file write data.
REQ-014 Port: pc_out  output  7  pc of the instruction being retired.
REQ-015 Port: retired  output  1  one-cycle pulse when an instruction completes.
REQ-016 Port: timeout_err  output  1  one-cycle pulse when a load is abandoned.

Function
REQ-017 Handshake: accept when valid_in=1 and ready_out=1; ready_out=1 in IDLE and COMMIT, 0 in WAIT_MEM.
REQ-018 Decode at acceptance: cond=instr_in[31:28]; rd=instr_in[15:12]; load = instr_in[27:26]=01 and instr_in[20]=1; dp-write = instr_in[27:26]=00 and not (instr_in[24:23]=10 and instr_in[20]=1); cond=4'hF forces no write.
REQ-019 States: IDLE, WAIT_MEM, COMMIT; all outputs registered.
REQ-020 Non-load accepted in cycle N -> COMMIT in N+1: retired=1, pc_out=pc_in, w_en=dp-write, w_addr=rd, w_data=alu_in captured at acceptance.
REQ-021 Load accepted -> WAIT_MEM; 8-bit wait counter cleared on entry, incremented each WAIT_MEM cycle.
REQ-022 WAIT_MEM with mem_rvalid=1 -> COMMIT next cycle: w_en=1, w_addr=rd, w_data=mem_rdata sampled that edge, retired=1.
REQ-023 WAIT_MEM with counter=TIMEOUT-1 and mem_rvalid=0 -> COMMIT with w_en=0, retired=1, timeout_err=1.
REQ-024 Simultaneous mem_rvalid and timeout on same cycle: data wins, timeout_err=0.
REQ-025 mem_rvalid outside WAIT_MEM ignored (except REQ-033).
REQ-026 COMMIT lasts exactly one cycle; an instruction accepted in COMMIT proceeds per REQ-020/021 (back-to-back throughput 1/cycle for non-loads).
REQ-027 COMMIT with no acceptance -> IDLE; in IDLE/WAIT_MEM, w_en=retired=timeout_err=0.
REQ-028 w_addr/w_data/pc_out hold last committed values when w_en=0.

Reset
REQ-029 rst_n=0 asynchronously forces IDLE, counter=0, w_en=0, retired=0, timeout_err=0, w_addr=0, w_data=0, pc_out=0.
REQ-030 ready_out=1 during and immediately after reset.
REQ-031 Reset during WAIT_MEM discards the pending load: no w_en, no retired, no timeout_err afterwards.
REQ-032 First acceptance possible on first rising edge with rst_n=1.

Configuration
REQ-033 Macro WB_LOAD_BYPASS_EN defined: a load accepted with mem_rvalid=1 in the same cycle skips WAIT_MEM and commits next cycle with that mem_rdata.
REQ-034 WB_LOAD_BYPASS_EN undefined: mem_rvalid in the acceptance cycle ignored; every load spends at least one WAIT_MEM cycle.

Verification
REQ-035 ADD r3 (instr 32'hE0813002, pc 7'h10, alu_in 32'h55) accepted cycle N -> cycle N+1 w_en=1, w_addr=3, w_data=32'h55, pc_out=7'h10, retired=1.
REQ-036 LDR r2 (32'hE5912000), mem_rvalid=1 with mem_rdata=32'hDEADBEEF three cycles after acceptance -> ready_out=0 during wait, next cycle w_en=1, w_addr=2, w_data=32'hDEADBEEF.
REQ-037 LDR with mem_rvalid never asserted, TIMEOUT=8 -> timeout_err=1 and retired=1 exactly 9 cycles after acceptance, w_en=0.
REQ-038 CMP (32'hE1510002) then STR (32'hE5812000) back-to-back -> two retired pulses on consecutive cycles, w_en=0 both.
REQ-039 rst_n=0 for one cycle during WAIT_MEM, then mem_rvalid=1 -> no w_en, no retired; ready_out=1.
REQ-040 With WB_LOAD_BYPASS_EN, LDR accepted with mem_rvalid=1, mem_rdata=32'h1234 -> w_en=1, w_data=32'h1234 next cycle; without macro, load waits in WAIT_MEM.

Source files
------------

// File: rtl/memory_writeback_unit.sv
// Writeback stage: retires data-processing results and loads, waiting up to TIMEOUT cycles for load data.
// Optional macro WB_LOAD_BYPASS_EN lets a load commit straight away when its data arrives in the acceptance cycle.
module memory_writeback_unit #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] instr_in,
  input  logic [6:0]  pc_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        w_en,
  output logic [3:0]  w_addr,
  output logic [31:0] w_data,
  output logic [6:0]  pc_out,
  output logic        retired,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  ld_rd, ld_rd_nxt;
  logic [6:0]  ld_pc, ld_pc_nxt;
  logic        ld_wr, ld_wr_nxt;
  logic        w_en_nxt, retired_nxt, timeout_nxt;
  logic [3:0]  w_addr_nxt;
  logic [31:0] w_data_nxt;
  logic [6:0]  pc_out_nxt;

  logic accept, cond_nv, is_load, dp_wr, bypass;
  logic [3:0] rd;

  assign ready_out = (state != WAIT_MEM);
  assign accept    = valid_in && ready_out;
  assign cond_nv   = (instr_in[31:28] == 4'hF);
  assign rd        = instr_in[15:12];
  assign is_load   = (instr_in[27:26] == 2'b01) && instr_in[20];
  // Compare/test ops (opcode 10xx with S set) update flags only.
  assign dp_wr     = (instr_in[27:26] == 2'b00) && !((instr_in[24:23] == 2'b10) && instr_in[20]) && !cond_nv;

`ifdef WB_LOAD_BYPASS_EN
  assign bypass = mem_rvalid;
`else
  assign bypass = 1'b0;
`endif

  logic unused_instr;
  assign unused_instr = &{1'b0, instr_in[25], instr_in[22:21], instr_in[19:16], instr_in[11:0]};

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ld_rd_nxt   = ld_rd;
    ld_pc_nxt   = ld_pc;
    ld_wr_nxt   = ld_wr;
    w_en_nxt    = 1'b0;
    retired_nxt = 1'b0;
    timeout_nxt = 1'b0;
    w_addr_nxt  = w_addr;
    w_data_nxt  = w_data;
    pc_out_nxt  = pc_out;
    case (state)
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_nxt   = COMMIT;
          retired_nxt = 1'b1;
          pc_out_nxt  = ld_pc;
          w_en_nxt    = ld_wr;
          if (ld_wr) begin
            w_addr_nxt = ld_rd;
            w_data_nxt = mem_rdata;
          end
        end else if (cnt == LAST_WAIT) begin
          state_nxt   = COMMIT;
          retired_nxt = 1'b1;
          timeout_nxt = 1'b1;
          pc_out_nxt  = ld_pc;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        if (!accept) begin
          state_nxt = IDLE;
        end else if (is_load && !bypass) begin
          state_nxt = WAIT_MEM;
          cnt_nxt   = 8'd0;
          ld_rd_nxt = rd;
          ld_pc_nxt = pc_in;
          ld_wr_nxt = !cond_nv;
        end else begin
          // Non-load, or a load whose data is already on the bus.
          state_nxt   = COMMIT;
          retired_nxt = 1'b1;
          pc_out_nxt  = pc_in;
          w_en_nxt    = is_load ? !cond_nv : dp_wr;
          if (w_en_nxt) begin
            w_addr_nxt = rd;
            w_data_nxt = is_load ? mem_rdata : alu_in;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      ld_rd       <= 4'd0;
      ld_pc       <= 7'd0;
      ld_wr       <= 1'b0;
      w_en        <= 1'b0;
      retired     <= 1'b0;
      timeout_err <= 1'b0;
      w_addr      <= 4'd0;
      w_data      <= 32'd0;
      pc_out      <= 7'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ld_rd       <= ld_rd_nxt;
      ld_pc       <= ld_pc_nxt;
      ld_wr       <= ld_wr_nxt;
      w_en        <= w_en_nxt;
      retired     <= retired_nxt;
      timeout_err <= timeout_nxt;
      w_addr      <= w_addr_nxt;
      w_data      <= w_data_nxt;
      pc_out      <= pc_out_nxt;
    end
  end

endmodule

// File: tb/tb_memory_writeback_unit.sv
// Bench for memory_writeback_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_memory_writeback_unit;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] instr_in = '0;
  logic [6:0]  pc_in = '0;
  logic [31:0] alu_in = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        w_en, retired, timeout_err;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic [6:0]  pc_out;

  memory_writeback_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .instr_in(instr_in), .pc_in(pc_in), .alu_in(alu_in),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .pc_out(pc_out),
    .retired(retired), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: at most one load outstanding; retirement events computed from the instruction rules.
  bit          busy;
  int          waited;
  logic [3:0]  p_rd;
  logic [6:0]  p_pc;
  bit          p_wr;
  logic        e_wen, e_ret, e_to;
  logic [3:0]  e_addr;
  logic [31:0] e_data;
  logic [6:0]  e_pc;

`ifdef WB_LOAD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic bit f_load(input logic [31:0] i);
    return i[27:26] == 2'b01 && i[20];
  endfunction

  function automatic bit f_writes(input logic [31:0] i);
    if (i[31:28] == 4'hF) return 1'b0;
    if (f_load(i)) return 1'b1;
    return i[27:26] == 2'b00 && !(i[24:23] == 2'b10 && i[20]);
  endfunction

  task automatic retire(input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [6:0] p, input bit to);
    e_ret = 1'b1;
    e_to  = to;
    e_pc  = p;
    e_wen = wr;
    if (wr) begin
      e_addr = a;
      e_data = d;
    end
  endtask

  task automatic model_reset();
    busy = 0; waited = 0;
    e_wen = 0; e_ret = 0; e_to = 0; e_addr = '0; e_data = '0; e_pc = '0;
  endtask

  task automatic check_outs(input string ph);
    chk({ph, ".w_en"}, w_en, e_wen);
    chk({ph, ".retired"}, retired, e_ret);
    chk({ph, ".timeout_err"}, timeout_err, e_to);
    chk({ph, ".w_addr"}, w_addr, e_addr);
    chk({ph, ".w_data"}, w_data, e_data);
    chk({ph, ".pc_out"}, pc_out, e_pc);
  endtask

  // Called just after a negedge: drive one cycle of inputs, predict, and check after the next posedge.
  task automatic step(input string ph, input logic v, input logic [31:0] ins, input logic [6:0] p,
                      input logic [31:0] alu, input logic rv, input logic [31:0] rdat);
    valid_in = v; instr_in = ins; pc_in = p; alu_in = alu; mem_rvalid = rv; mem_rdata = rdat;
    chk({ph, ".ready_out"}, ready_out, !busy);
    e_wen = 0; e_ret = 0; e_to = 0;
    if (busy) begin
      if (rv) begin
        retire(p_wr, p_rd, rdat, p_pc, 0);
        busy = 0;
      end else begin
        waited++;
        if (waited == TIMEOUT) begin
          retire(0, '0, '0, p_pc, 1);
          busy = 0;
        end
      end
    end else if (v) begin
      if (f_load(ins) && !(BYPASS && rv)) begin
        busy = 1; waited = 0;
        p_rd = ins[15:12]; p_pc = p; p_wr = f_writes(ins);
      end else begin
        retire(f_writes(ins), ins[15:12], f_load(ins) ? rdat : alu, p, 0);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outs(ph);
  endtask

  task automatic idle(input string ph, input int n);
    for (int k = 0; k < n; k++) step(ph, 0, 32'h0, 7'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("reset");
    chk("reset.ready_out", ready_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset.ready_out", ready_out, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 5))
      0: i[27:26] = 2'b00;
      1: begin i[27:26] = 2'b01; i[20] = 1'b1; end
      2: begin i[27:26] = 2'b01; i[20] = 1'b0; end
      3: begin i[27:26] = 2'b00; i[24:23] = 2'b10; i[20] = 1'b1; end
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) i[31:28] = 4'hE;
    return i;
  endfunction

  initial begin
    @(negedge clk);
    do_reset();
    // ADD r3 then idle
    step("add", 1, 32'hE0813002, 7'h10, 32'h55, 0, 32'h0);
    idle("add_idle", 1);
    // LDR r2, data three cycles after acceptance
    step("ldr", 1, 32'hE5912000, 7'h20, 32'h0, 0, 32'h0);
    idle("ldr_wait", 2);
    step("ldr_data", 0, 32'h0, 7'h0, 32'h0, 1, 32'hDEADBEEF);
    idle("ldr_idle", 1);
    // LDR never answered: timeout
    step("ldr_to", 1, 32'hE5912000, 7'h21, 32'h0, 0, 32'h0);
    idle("ldr_to_wait", 10);
    // CMP then STR back to back
    step("cmp", 1, 32'hE1510002, 7'h30, 32'h77, 0, 32'h0);
    step("str", 1, 32'hE5812000, 7'h31, 32'h88, 0, 32'h0);
    idle("cmpstr_idle", 1);
    // reset during WAIT_MEM drops the load
    step("ldr_rst", 1, 32'hE5912000, 7'h40, 32'h0, 0, 32'h0);
    idle("ldr_rst_wait", 1);
    do_reset();
    step("ldr_rst_late", 0, 32'h0, 7'h0, 32'h0, 1, 32'hCAFEF00D);
    idle("ldr_rst_idle", 1);
    // load with data present in acceptance cycle
    step("ldr_same", 1, 32'hE5912000, 7'h50, 32'h0, 1, 32'h1234);
    idle("ldr_same_idle", 3);
    step("ldr_same_data", 0, 32'h0, 7'h0, 32'h0, 1, 32'h5678);
    idle("ldr_same_tail", 2);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step("rand", $urandom_range(0, 9) < 7, rand_instr(), 7'($urandom),
                $urandom, $urandom_range(0, 3) == 0, $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
